// File: rtl/cpu_pkg.sv
// Shared constants for the operand-fetch / register-file slice: register count,
// return-address index and instruction field positions.
package cpu_pkg;

    localparam int NREG   = 16;
    localparam int RA_IDX = 15;

    localparam int RD_HI  = 25;
    localparam int RD_LO  = 22;
    localparam int RS1_HI = 21;
    localparam int RS1_LO = 18;
    localparam int RS2_HI = 17;
    localparam int RS2_LO = 14;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
    } operands_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register in-flight write counters. busy/full are reported as seen after
// this cycle's commit, so a write-back retiring the last pending write unblocks issue.
module reg_scoreboard #(
    parameter  int NREG   = 16,
    parameter  int PEND_W = 2,
    localparam int AW     = $clog2(NREG)
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            inc_i,
    input  logic [AW-1:0]   inc_addr_i,
    input  logic            dec_i,
    input  logic [AW-1:0]   dec_addr_i,
    input  logic            fdec_i,
    input  logic [AW-1:0]   fdec_addr_i,
    output logic [NREG-1:0] busy_o,
    output logic [NREG-1:0] full_o
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    for (genvar r = 0; r < NREG; r++) begin : g_cnt
        logic              hit_inc, hit_dec, hit_fdec;
        logic [PEND_W-1:0] cnt_q, cnt_d, after_commit;
        logic [PEND_W+1:0] base, take, diff;

        assign hit_inc  = inc_i  && (inc_addr_i  == AW'(r));
        assign hit_dec  = dec_i  && (dec_addr_i  == AW'(r));
        assign hit_fdec = fdec_i && (fdec_addr_i == AW'(r));

        assign after_commit = (hit_dec && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        assign busy_o[r]    = (after_commit != '0);
        assign full_o[r]    = (after_commit == PEND_MAX);

        // Net sum of issue, commit and flush-drop; going below zero clamps.
        assign base = {2'b00, cnt_q} + {{(PEND_W+1){1'b0}}, hit_inc};
        assign take = {{(PEND_W+1){1'b0}}, hit_dec} + {{(PEND_W+1){1'b0}}, hit_fdec};
        assign diff = base - take;
        assign cnt_d = (base <= take)               ? '0 :
                       (diff > {2'b00, PEND_MAX})   ? PEND_MAX :
                                                      diff[PEND_W-1:0];

        always_ff @(posedge clk_i) begin
            if (reset_i) cnt_q <= '0;
            else         cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/operand_fetch_rf.sv
// Register file with write-back bypass, RAW scoreboard and a registered
// valid/ready operand stage feeding execute.
module operand_fetch_rf #(
    parameter  int NREG   = cpu_pkg::NREG,
    parameter  int PEND_W = 2,
    localparam int AW     = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inValid,
    output logic          inReady,
    input  logic [31:0]   instruction,
    input  logic          useRs1,
    input  logic          useRs2,
    input  logic          isSt,
    input  logic          isRet,
    input  logic          isWb,
    input  logic          isCall,
    output logic          outValid,
    input  logic          outReady,
    output logic [31:0]   op1,
    output logic [31:0]   op2,
    output logic [AW-1:0] destAddr,
    output logic          destWb,
    input  logic          flush,
    input  logic          wbEn,
    input  logic [AW-1:0] writeRegAddr,
    input  logic [31:0]   writeData
);

    import cpu_pkg::*;

    logic [AW-1:0]          rd, rs1, rs2, s1, s2, dst;
    logic [NREG-1:0][31:0]  regs_q;
    operands_t              ops_q, ops_d;
    logic                   out_valid_q, dest_wb_q;
    logic [AW-1:0]          dest_q;
    logic [NREG-1:0]        busy, full;
    logic                   hazard, accept;
    logic                   unused_fields;

    assign rd  = instruction[RD_HI:RD_LO];
    assign rs1 = instruction[RS1_HI:RS1_LO];
    assign rs2 = instruction[RS2_HI:RS2_LO];
    assign unused_fields = ^{instruction[31:26], instruction[13:0]};

    assign s1  = isRet  ? AW'(RA_IDX) : rs1;
    assign s2  = isSt   ? rd          : rs2;
    assign dst = isCall ? AW'(RA_IDX) : rd;

    // Same-cycle write-back wins over the stored value.
    assign ops_d.op1 = (wbEn && writeRegAddr == s1) ? writeData : regs_q[s1];
    assign ops_d.op2 = (wbEn && writeRegAddr == s2) ? writeData : regs_q[s2];

    assign hazard  = (useRs1 && busy[s1]) || (useRs2 && busy[s2]) || (isWb && full[dst]);
    assign inReady = !hazard && (!out_valid_q || outReady) && !flush;
    assign accept  = inValid && inReady;

    reg_scoreboard #(.NREG(NREG), .PEND_W(PEND_W)) u_sb (
        .clk_i       (clk),
        .reset_i     (reset),
        .inc_i       (accept && isWb),
        .inc_addr_i  (dst),
        .dec_i       (wbEn),
        .dec_addr_i  (writeRegAddr),
        .fdec_i      (flush && out_valid_q && dest_wb_q),
        .fdec_addr_i (dest_q),
        .busy_o      (busy),
        .full_o      (full)
    );

    always_ff @(posedge clk) begin
        if (reset)     regs_q <= '0;
        else if (wbEn) regs_q[writeRegAddr] <= writeData;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            ops_q       <= '0;
            dest_q      <= '0;
            dest_wb_q   <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            ops_q       <= ops_d;
            dest_q      <= dst;
            dest_wb_q   <= isWb;
        end else if (outReady) begin
            out_valid_q <= 1'b0;
        end
    end

    assign outValid = out_valid_q;
    assign op1      = ops_q.op1;
    assign op2      = ops_q.op2;
    assign destAddr = dest_q;
    assign destWb   = dest_wb_q;

endmodule

// File: tb/tb_operand_fetch_rf.sv
// Scoreboard bench: a register/pending-count model predicts inReady and the
// operand bundle of every accept; a monitor pops and compares on each consume.
module tb_operand_fetch_rf;

    logic        clk = 1'b0;
    logic        reset, inValid, inReady, useRs1, useRs2, isSt, isRet, isWb, isCall;
    logic        outValid, outReady, destWb, flush, wbEn;
    logic [31:0] instruction, op1, op2, writeData;
    logic [3:0]  destAddr, writeRegAddr;

    operand_fetch_rf dut (
        .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
        .instruction(instruction), .useRs1(useRs1), .useRs2(useRs2), .isSt(isSt),
        .isRet(isRet), .isWb(isWb), .isCall(isCall), .outValid(outValid),
        .outReady(outReady), .op1(op1), .op2(op2), .destAddr(destAddr),
        .destWb(destWb), .flush(flush), .wbEn(wbEn), .writeRegAddr(writeRegAddr),
        .writeData(writeData)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  dest;
        logic        wb;
    } exp_t;

    exp_t        q[$];
    int          checks = 0, errors = 0;
    logic [31:0] mregs[16];
    int          mpend[16];
    bit          mOv, mWb, lastRdy;
    int          mDest;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every consumed output against the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (!reset && outValid && outReady) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL out_unexpected actual=outValid required=no_pending_output");
            end else begin
                e = q.pop_front();
                chk("out_op1", op1, e.op1);
                chk("out_op2", op2, e.op2);
                chk("out_dest", {28'b0, destAddr}, {28'b0, e.dest});
                chk("out_destWb", {31'b0, destWb}, {31'b0, e.wb});
            end
        end
    end

    // Evaluate one cycle of the reference model, then advance to the next negedge.
    task automatic cyc();
        int   s1, s2, d, wa;
        int   p[16], np[16];
        bit   haz, er, acc;
        exp_t e;
        #1;
        if (reset) begin
            for (int r = 0; r < 16; r++) begin mregs[r] = '0; mpend[r] = 0; end
            mOv = 0; mWb = 0; mDest = 0; q.delete(); lastRdy = 0;
        end else begin
            chk("outValid", {31'b0, outValid}, {31'b0, mOv});
            s1 = isRet  ? 15 : int'(instruction[21:18]);
            s2 = isSt   ? int'(instruction[25:22]) : int'(instruction[17:14]);
            d  = isCall ? 15 : int'(instruction[25:22]);
            wa = int'(writeRegAddr);
            for (int r = 0; r < 16; r++) begin p[r] = mpend[r]; np[r] = mpend[r]; end
            if (wbEn && p[wa] > 0) p[wa]--;
            haz = (useRs1 && p[s1] != 0) || (useRs2 && p[s2] != 0) || (isWb && p[d] == 3);
            er  = !haz && (!mOv || outReady) && !flush;
            chk("inReady", {31'b0, inReady}, {31'b0, er});
            lastRdy = inReady;
            acc = inValid && er;
            if (acc) begin
                e.op1  = (wbEn && wa == s1) ? writeData : mregs[s1];
                e.op2  = (wbEn && wa == s2) ? writeData : mregs[s2];
                e.dest = 4'(d);
                e.wb   = isWb;
                q.push_back(e);
            end
            if (acc && isWb)          np[d]++;
            if (wbEn)                 np[wa]--;
            if (flush && mOv && mWb)  np[mDest]--;
            for (int r = 0; r < 16; r++) mpend[r] = (np[r] < 0) ? 0 : np[r];
            if (wbEn) mregs[wa] = writeData;
            if (flush) begin
                if (mOv && q.size() > 0) e = q.pop_front();
                mOv = 0;
            end else if (acc) begin
                mOv = 1; mDest = d; mWb = isWb;
            end else if (outReady) begin
                mOv = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic drv(input int rd, input int rs1, input int rs2, input bit v,
                       input bit u1, input bit u2, input bit st, input bit ret,
                       input bit wb, input bit call);
        instruction = {6'($urandom), 4'(rd), 4'(rs1), 4'(rs2), 14'($urandom)};
        inValid = v; useRs1 = u1; useRs2 = u2; isSt = st; isRet = ret; isWb = wb; isCall = call;
    endtask

    task automatic commit(input bit en, input int a, input logic [31:0] data);
        wbEn = en; writeRegAddr = 4'(a); writeData = data;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        idle(); commit(0, 0, 0); flush = 0; outReady = 1; reset = 1;
        @(negedge clk);
        cyc(); cyc();
        reset = 0;
        chk("reset_outValid", {31'b0, outValid}, 0);
        chk("reset_op1", op1, 0);

        // r3 = 0xAA, then add r4 <- r3, r3
        commit(1, 3, 32'hAA); cyc(); commit(0, 0, 0);
        drv(4, 3, 3, 1, 1, 1, 0, 0, 1, 0); cyc(); idle();
        chk("add_op1", op1, 32'hAA);
        chk("add_op2", op2, 32'hAA);
        commit(1, 4, 32'h44); cyc(); commit(0, 0, 0);

        // call then ret: ret waits for r15 and is accepted on the commit cycle
        drv(1, 0, 0, 1, 0, 0, 0, 0, 1, 1); cyc();
        drv(0, 0, 0, 1, 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin cyc(); chk("ret_stall", {31'b0, lastRdy}, 0); end
        commit(1, 15, 32'h104); cyc(); commit(0, 0, 0); idle();
        chk("ret_accept", {31'b0, lastRdy}, 1);
        chk("ret_op1", op1, 32'h104);

        // saturate pend[5]
        drv(5, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin cyc(); chk("sat_issue", {31'b0, lastRdy}, 1); end
        cyc(); chk("sat_stall", {31'b0, lastRdy}, 0);
        commit(1, 5, 32'h55); cyc(); commit(0, 0, 0);
        chk("sat_commit_issue", {31'b0, lastRdy}, 1);
        cyc(); chk("sat_still_full", {31'b0, lastRdy}, 0);
        idle();
        for (int i = 0; i < 3; i++) begin commit(1, 5, 32'h55); cyc(); end
        commit(0, 0, 0);

        // hold outputs with outReady low
        outReady = 0;
        drv(6, 3, 5, 1, 1, 1, 0, 0, 1, 0); cyc();
        chk("hold_first_accept", {31'b0, lastRdy}, 1);
        drv(0, 3, 3, 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("hold_inReady", {31'b0, lastRdy}, 0);
            chk("hold_op1", op1, 32'hAA);
            chk("hold_op2", op2, 32'h55);
            chk("hold_dest", {28'b0, destAddr}, 6);
        end
        outReady = 1; cyc();
        chk("release_accept", {31'b0, lastRdy}, 1);
        idle(); commit(1, 6, 32'h66); cyc(); commit(0, 0, 0);

        // flush a held writer to r7
        outReady = 0;
        drv(7, 0, 0, 1, 0, 0, 0, 0, 1, 0); cyc();
        flush = 1; drv(0, 3, 0, 1, 1, 0, 0, 0, 0, 0); cyc();
        chk("flush_block", {31'b0, lastRdy}, 0);
        flush = 0; idle();
        chk("flush_drop", {31'b0, outValid}, 0);
        outReady = 1; drv(0, 7, 0, 1, 1, 0, 0, 0, 0, 0); cyc();
        chk("flush_nostall", {31'b0, lastRdy}, 1);
        idle(); cyc();

        // store waits only on rd
        drv(2, 0, 0, 1, 0, 0, 0, 0, 1, 0); cyc();
        drv(2, 0, 9, 1, 0, 1, 1, 0, 0, 0); cyc();
        chk("st_stall", {31'b0, lastRdy}, 0);
        commit(1, 2, 32'h22); cyc(); commit(0, 0, 0); idle();
        chk("st_accept", {31'b0, lastRdy}, 1);
        chk("st_op2", op2, 32'h22);

        // reset during hold clears everything
        outReady = 0;
        drv(8, 0, 0, 1, 0, 0, 0, 0, 1, 0); cyc();
        reset = 1; cyc(); reset = 0;
        chk("rst_hold_outValid", {31'b0, outValid}, 0);
        outReady = 1; drv(1, 8, 0, 1, 1, 0, 0, 0, 0, 0); cyc();
        chk("rst_first_accept", {31'b0, lastRdy}, 1);

        // randomized traffic over a small register window to provoke hazards
        for (int i = 0; i < 600; i++) begin
            drv($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
                ($urandom % 4) != 0, $urandom % 2, $urandom % 2, ($urandom % 4) == 0,
                ($urandom % 6) == 0, $urandom % 2, ($urandom % 6) == 0);
            commit(($urandom % 3) == 0, $urandom_range(0, 5), $urandom);
            if ($urandom % 8 == 0) commit(1, 15, $urandom);
            flush    = ($urandom % 16) == 0;
            outReady = flush ? 1'b0 : (($urandom % 4) != 0);
            cyc();
        end
        idle(); commit(0, 0, 0); flush = 0; outReady = 1;
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
